// File: rtl/alu.sv
// 64-bit Y86 execute ALU: combinational add/sub/and/xor with signed overflow, plus ZF/SF/OF flag registers.
// Zero-latency datapath; flags load one clock edge after set_cc, no backpressure (no handshake).
module alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       S0,
    input  logic             set_cc,
    output logic [WIDTH-1:0] Z,
    output logic             ovf,
    output logic             zf_q,
    output logic             sf_q,
    output logic             of_q
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_XOR = 2'b11;

    logic             is_sub;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_cin;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    // Subtract is Y + ~X + 1 through the same adder; carry-out is dropped.
    assign is_sub  = (S0 == FN_SUB);
    assign add_a   = is_sub ? ~X : X;
    assign add_cin = {{(WIDTH-1){1'b0}}, is_sub};
    assign sum     = Y + add_a + add_cin;

    // Overflow when both adder inputs share a sign that the sum does not.
    // For subtract this reduces to X[MSB] != Y[MSB] && Z[MSB] != Y[MSB].
    assign sum_ovf = (add_a[MSB] == Y[MSB]) && (sum[MSB] != Y[MSB]);

    always_comb begin
        Z   = sum;
        ovf = 1'b0;
        unique case (S0)
            FN_ADD: begin
                Z   = sum;
                ovf = sum_ovf;
            end
            FN_SUB: begin
                Z   = sum;
                ovf = sum_ovf;
            end
            FN_AND: Z = X & Y;
            FN_XOR: Z = X ^ Y;
            default: begin
                Z   = sum;
                ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (set_cc) begin
            zf_q <= (Z == '0);
            sf_q <= Z[MSB];
            of_q <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: datapath vectors, overflow corners and flag register behaviour.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [63:0] X;
    logic [63:0] Y;
    logic [1:0]  S0;
    logic        set_cc;
    logic [63:0] Z;
    logic        ovf;
    logic        zf_q;
    logic        sf_q;
    logic        of_q;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .X      (X),
        .Y      (Y),
        .S0     (S0),
        .set_cc (set_cc),
        .Z      (Z),
        .ovf    (ovf),
        .zf_q   (zf_q),
        .sf_q   (sf_q),
        .of_q   (of_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
        S0 = s;
        X  = a;
        Y  = b;
        #1;
    endtask

    task automatic check_flags(input string tag, input logic zf, input logic sf, input logic of);
        check({tag, "_zf"}, {63'd0, zf_q}, {63'd0, zf});
        check({tag, "_sf"}, {63'd0, sf_q}, {63'd0, sf});
        check({tag, "_of"}, {63'd0, of_q}, {63'd0, of});
    endtask

    initial begin
        reset  = 1'b1;
        set_cc = 1'b0;
        S0     = 2'b00;
        X      = 64'd0;
        Y      = 64'd0;
        #2;
        check_flags("reset", 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b0;

        // Addition
        drive(2'b00, 64'd5, 64'd3);
        check("add_5_3_z", Z, 64'd8);
        check("add_5_3_ovf", {63'd0, ovf}, 64'd0);
        drive(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10);
        check("add_m1_10_z", Z, 64'd9);
        check("add_m1_10_ovf", {63'd0, ovf}, 64'd0);

        // Subtraction is Y - X
        drive(2'b01, 64'd3, 64'd10);
        check("sub_10_3_z", Z, 64'd7);
        check("sub_10_3_ovf", {63'd0, ovf}, 64'd0);
        drive(2'b01, 64'd1, 64'd0);
        check("sub_0_1_z", Z, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_0_1_ovf", {63'd0, ovf}, 64'd0);
        set_cc = 1'b1;
        @(posedge clk); #1;
        set_cc = 1'b0;
        check_flags("cc_neg", 1'b0, 1'b1, 1'b0);

        // Overflow corners
        @(negedge clk);
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_ovf_z", Z, 64'h8000_0000_0000_0000);
        check("add_ovf_ovf", {63'd0, ovf}, 64'd1);
        set_cc = 1'b1;
        @(posedge clk); #1;
        set_cc = 1'b0;
        check_flags("cc_ovf", 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(2'b01, 64'd1, 64'h8000_0000_0000_0000);
        check("sub_ovf_z", Z, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_ovf_ovf", {63'd0, ovf}, 64'd1);
        drive(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        check("add_minneg_z", Z, 64'd0);
        check("add_minneg_ovf", {63'd0, ovf}, 64'd1);
        drive(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        check("sub_minneg_z", Z, 64'd0);
        check("sub_minneg_ovf", {63'd0, ovf}, 64'd0);

        // Logic ops never overflow
        drive(2'b10, 64'hF0F0, 64'hFF00);
        check("and_z", Z, 64'hF000);
        check("and_ovf", {63'd0, ovf}, 64'd0);
        drive(2'b11, 64'h1234, 64'h1234);
        check("xor_z", Z, 64'd0);
        check("xor_ovf", {63'd0, ovf}, 64'd0);
        set_cc = 1'b1;
        @(posedge clk); #1;
        set_cc = 1'b0;
        check_flags("cc_zero", 1'b1, 1'b0, 1'b0);

        // Flags hold while set_cc is low
        @(negedge clk);
        drive(2'b00, 64'd5, 64'd3);
        check("hold_z", Z, 64'd8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check_flags("hold", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);

        // Reset beats set_cc at an edge
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        set_cc = 1'b1;
        @(posedge clk); #1;
        check_flags("rst_prio", 1'b0, 1'b0, 1'b0);

        // Release reset mid-cycle; flags stay clear until the next qualifying edge
        @(negedge clk);
        #2;
        reset  = 1'b0;
        set_cc = 1'b0;
        #1;
        check_flags("rst_release", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_flags("post_rst_idle", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_cc = 1'b1;
        @(posedge clk); #1;
        set_cc = 1'b0;
        check_flags("post_rst_load", 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 64-bit integer ALU for the Y86 execute stage.
- Performs add, subtract, AND and XOR on two 64-bit operands, with a combinational result and a signed-overflow flag.
- Also holds an optional registered copy of the condition flags (ZF/SF/OF), updated on a clock edge when enabled.
- The execute stage drives X = valA or valC, Y = valB, and S0 = ifun[1:0] for OPq, or 2'b00 for address and stack-pointer arithmetic.

Parameters:
- WIDTH, 64, operand/result width in bits. Only 64 is required to be supported.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset; clears the registered flags.
- X  input  64  operand A; signed two's complement.
- Y  input  64  operand B; signed two's complement.
- S0  input  2  function select: 00 add, 01 sub, 10 and, 11 xor.
- set_cc  input  1  when high at a rising clk, load the flag registers from the current result.
- Z  output  64  combinational result.
- ovf  output  1  combinational signed overflow of the current operation.
- zf_q  output  1  registered zero flag.
- sf_q  output  1  registered sign flag.
- of_q  output  1  registered overflow flag.

Behaviour:
- Datapath (Z, ovf) is purely combinational; zero latency. Z follows any change of X, Y or S0 in the same cycle, independent of clk and reset.
- S0=00: Z = X + Y, modulo 2^64. ovf = 1 iff X[63]==Y[63] and Z[63]!=X[63].
- S0=01: Z = Y - X, modulo 2^64 (Y86 subq order: valB - valA). ovf = 1 iff X[63]!=Y[63] and Z[63]!=Y[63].
- S0=10: Z = X & Y; ovf = 0.
- S0=11: Z = X ^ Y; ovf = 0.
- Subtraction is implemented as Y + ~X + 1 in a single adder. There is no carry-out port; the carry is discarded.
- Most-negative operand (0x8000_0000_0000_0000) follows the same wrap and overflow rules with no special casing.
- Flag registers:
  - reset high (asynchronous, any time): zf_q = sf_q = of_q = 0 immediately.
  - Reset has priority over set_cc.
  - On rising clk with reset low and set_cc=1: zf_q <= (Z==0); sf_q <= Z[63]; of_q <= ovf. Values are those present just before the edge.
  - set_cc=0: flags hold their value.
  - Flags update for any S0 value. For AND/XOR, of_q loads 0.
- Reset deasserted mid-cycle: flags remain 0 until the next qualifying edge.
- No X/Z propagation from internal state: every output is defined from reset onward, given defined inputs.
- No handshake and no state machine beyond the three flag flip-flops.

Test Plan:
- S0=00, X=5, Y=3 -> Z=8, ovf=0. Then X=0xFFFF_FFFF_FFFF_FFFF (-1), Y=10 -> Z=9, ovf=0.
- S0=01, X=3, Y=10 -> Z=7, ovf=0. Then X=1, Y=0 -> Z=0xFFFF_FFFF_FFFF_FFFF, ovf=0. With set_cc=1, after the edge: zf_q=0, sf_q=1, of_q=0.
- S0=00, X=0x7FFF_FFFF_FFFF_FFFF, Y=1 -> Z=0x8000_0000_0000_0000, ovf=1. S0=01, X=1, Y=0x8000_0000_0000_0000 -> Z=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- S0=10, X=0xF0F0, Y=0xFF00 -> Z=0xF000, ovf=0. S0=11, X=Y=0x1234 -> Z=0, ovf=0. With set_cc=1 -> zf_q=1, sf_q=0, of_q=0.
- Flags held then reset: set flags to zf_q=1, then set_cc=0 with Z nonzero for 3 edges -> zf_q stays 1. Assert reset between edges -> all flags 0 immediately. Reset and set_cc both high at an edge -> flags stay 0.
